// File: rtl/uart_transmitter_if.sv
// Data-bus port of the UART transmitter: the CPU-side register access group.
// The master drives address/data/strobe; the slave returns the registered read word.
interface uart_transmitter_if;
    logic [3:0]  data_addr;
    logic [31:0] data_in;
    logic        write_enable;
    logic [1:0]  window_size;
    logic [31:0] data_out;

    modport master (
        output data_addr,
        output data_in,
        output write_enable,
        output window_size,
        input  data_out
    );

    modport slave (
        input  data_addr,
        input  data_in,
        input  write_enable,
        input  window_size,
        output data_out
    );
endinterface

// File: rtl/uart_transmitter.sv
// Memory-mapped 8N1 UART transmitter: CPU writes bytes into a FIFO, a frame FSM
// shifts them out LSB first at CLKS_PER_BIT clocks per bit with no gap between frames.
module uart_transmitter #(
    parameter int CLKS_PER_BIT    = 434,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_transmitter_if.slave   bus,
    output logic                uart_tx,
    output logic                busy,
    output logic [1:0]          fsm_state
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        fifo_mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              overflow;
    logic [CNT_W-1:0]  baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              tx_bit;
    logic              pop;
    logic              push_req;
    logic              push;
    logic              clear_ovf;
    logic              full;
    logic              empty;
    logic              baud_done;
    logic [31:0]       status;
    logic              unused_bits;

    assign unused_bits = ^{bus.window_size, bus.data_in[31:8], bus.data_addr[1:0]};

    // Register decode: word address 0 is TXDATA, 1 is STATUS, 2/3 reserved.
    assign push_req  = bus.write_enable && (bus.data_addr[3:2] == 2'd0);
    assign clear_ovf = bus.write_enable && (bus.data_addr[3:2] == 2'd1) && bus.data_in[3];
    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    // Full is judged on the pre-edge count, so a concurrent pop never rescues a push.
    assign push      = push_req && !full;
    assign baud_done = (baud_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.data_in[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_bit     = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx_bit = 1'b0;
                if (baud_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_bit = shift[0];
                if (baud_done && (bit_idx == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more data is queued.
                if (baud_done) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            if ((state == IDLE) || (state_next != state) || baud_done) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            if (pop) begin
                shift <= fifo_mem[rd_ptr];
            end else if ((state == DATA) && baud_done) begin
                shift <= {1'b0, shift[7:1]};
            end
            if (state == START) begin
                bit_idx <= '0;
            end else if ((state == DATA) && baud_done) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // Status word; the count field is 4 bits wide, sized for depths up to 8.
    always_comb begin
        status       = '0;
        status[0]    = full;
        status[1]    = empty;
        status[2]    = (state != IDLE);
        status[3]    = overflow;
        status[11:8] = 4'(count);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.data_out <= '0;
        end else begin
            case (bus.data_addr[3:2])
                2'd1:    bus.data_out <= status;
                default: bus.data_out <= '0;
            endcase
        end
    end

    assign uart_tx   = tx_bit;
    assign busy      = !empty || (state != IDLE);
    assign fsm_state = state;
endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a line decoder pops expected bytes from a
// scoreboard queue, while per-feature tasks check timing, status and reset behaviour.
module tb_uart_transmitter;
    localparam int CPB  = 4;
    localparam int DLOG = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_tx;
    logic       busy;
    logic [1:0] fsm_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    uart_transmitter_if bus();

    uart_transmitter #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH_LOG2(DLOG)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .uart_tx(uart_tx),
        .busy(busy),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Line decoder: samples at falling edges, mid-bit.
    logic       mon_busy = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_shift = '0;
    logic [7:0] want;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (uart_tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 2) begin
                total++;
                if (uart_tx !== 1'b0) begin
                    bad++;
                    $display("FAIL start_bit got=%b exp=0", uart_tx);
                end
            end
            if (mon_cnt > CPB && mon_cnt < 9 * CPB && (mon_cnt % CPB) == 1) begin
                mon_shift = {uart_tx, mon_shift[7:1]};
            end
            if (mon_cnt == 9 * CPB + 1) begin
                total++;
                if (uart_tx !== 1'b1) begin
                    bad++;
                    $display("FAIL stop_bit got=%b exp=1", uart_tx);
                end
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_frame got=%h exp=none", mon_shift);
                end else begin
                    want = exp_q.pop_front();
                    if (mon_shift !== want) begin
                        bad++;
                        $display("FAIL frame_byte got=%h exp=%h", mon_shift, want);
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        bus.data_addr    = a;
        bus.data_in      = d;
        bus.write_enable = 1'b1;
        @(posedge clk);
        #1;
        bus.write_enable = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [31:0] d);
        bus.data_addr    = a;
        bus.write_enable = 1'b0;
        @(posedge clk);
        #1;
        d = bus.data_out;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while ((busy || mon_busy || exp_q.size() != 0) && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        total++;
        if (n >= limit) begin
            bad++;
            $display("FAIL drain_timeout got=%0d pending exp=0 pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++;
        if (bus.data_out !== 32'h0) begin bad++; $display("FAIL reset_dout got=%h exp=0", bus.data_out); end
        rst_n = 1'b1;
        read_reg(4'h4, d);
        total++;
        if (d !== 32'h0000_0002) begin bad++; $display("FAIL reset_status got=%h exp=00000002", d); end
        read_reg(4'hC, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reserved_read got=%h exp=0", d); end
    endtask

    task automatic test_single_byte();
        logic [7:0] b;
        logic       e;
        b = 8'hA5;
        exp_q.push_back(b);
        write_reg(4'h0, {24'h0, b});
        for (int j = 0; j <= 41; j++) begin
            @(negedge clk);
            if (j == 0) e = 1'b1;
            else if (j <= CPB) e = 1'b0;
            else if (j <= 9 * CPB) e = b[(j - CPB - 1) / CPB];
            else e = 1'b1;
            total++;
            if (uart_tx !== e) begin bad++; $display("FAIL single_tx_j%0d got=%b exp=%b", j, uart_tx, e); end
            if (j == 0 || j == 40) begin
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_j%0d got=%b exp=1", j, busy); end
            end
            if (j == 41) begin
                total++;
                if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_fall got=%b exp=0", busy); end
            end
        end
        wait_done(200);
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h55;
        start_q.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(bytes[i]);
            bus.data_addr    = 4'h0;
            bus.data_in      = {24'h0, bytes[i]};
            bus.write_enable = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.write_enable = 1'b0;
        wait_done(400);
        total++;
        if (start_q.size() != 3) begin
            bad++;
            $display("FAIL b2b_frames got=%0d exp=3", start_q.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                total++;
                if (start_q[i] - start_q[i-1] != 10 * CPB) begin
                    bad++;
                    $display("FAIL b2b_gap%0d got=%0d exp=%0d", i, start_q[i] - start_q[i-1], 10 * CPB);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        for (int i = 1; i <= 10; i++) begin
            if (i <= 9) exp_q.push_back(8'(i));
            bus.data_addr    = 4'h0;
            bus.data_in      = 32'(i);
            bus.write_enable = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.write_enable = 1'b0;
        read_reg(4'h4, d);
        total++;
        if (d !== 32'h0000_080D) begin bad++; $display("FAIL ovf_status got=%h exp=0000080d", d); end
        read_reg(4'h0, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL txdata_read got=%h exp=0", d); end
        write_reg(4'h8, 32'h0000_00EE);
        write_reg(4'h4, 32'h0000_0008);
        read_reg(4'h4, d);
        total++;
        if (d !== 32'h0000_0805) begin bad++; $display("FAIL ovf_clear got=%h exp=00000805", d); end
        wait_done(1000);
        read_reg(4'h4, d);
        total++;
        if (d !== 32'h0000_0002) begin bad++; $display("FAIL ovf_drained got=%h exp=00000002", d); end
    endtask

    task automatic test_pointer_wrap();
        logic [31:0] d;
        logic [7:0]  v;
        int          n;
        for (int i = 0; i < 20; i++) begin
            n = 0;
            do begin
                read_reg(4'h4, d);
                n++;
            end while (d[0] && n < 2000);
            if (n >= 2000) begin
                total++;
                bad++;
                $display("FAIL wrap_full_timeout got=%h exp=not_full", d);
            end
            v = 8'($urandom_range(0, 255));
            exp_q.push_back(v);
            write_reg(4'h0, {24'h0, v});
        end
        wait_done(2000);
        read_reg(4'h4, d);
        total++;
        if (d !== 32'h0000_0002) begin bad++; $display("FAIL wrap_status got=%h exp=00000002", d); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        int          highs;
        for (int i = 0; i < 3; i++) begin
            bus.data_addr    = 4'h0;
            bus.data_in      = 32'h0000_0030 + 32'(i);
            bus.write_enable = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.write_enable = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        total++;
        if (fsm_state !== 2'd2) begin bad++; $display("FAIL midframe_state got=%0d exp=2", fsm_state); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL midframe_tx got=%b exp=1", uart_tx); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL midframe_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        read_reg(4'h4, d);
        total++;
        if (d !== 32'h0000_0002) begin bad++; $display("FAIL midframe_status got=%h exp=00000002", d); end
        highs = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (uart_tx === 1'b1) highs++;
        end
        total++;
        if (highs != 100) begin bad++; $display("FAIL midframe_quiet got=%0d exp=100", highs); end
    endtask

    initial begin
        bus.data_addr    = 4'h0;
        bus.data_in      = 32'h0;
        bus.write_enable = 1'b0;
        bus.window_size  = 2'd2;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_pointer_wrap();
        test_reset_mid_frame();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL leftover_expected got=%0d exp=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Memory-mapped UART transmitter (8N1, LSB first) that gives the SoC a serial return path towards the STM32 host, complementing the existing instruction-receiving UART controller. The CPU writes bytes through the data bus into an internal FIFO; a frame FSM serialises them onto `uart_tx` at a fixed baud rate. It sits on the data side of the memory controller as a new data device, with reads returning status through the same one-cycle-delayed read path the other devices use.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH_LOG2`, 3, FIFO depth = 2^FIFO_DEPTH_LOG2 bytes (default 8).

- `clk` input 1 — system clock; all state changes on its rising edge.
- `rst_n` input 1 — synchronous, active-low reset.
- `data_addr` input 4 — device-local byte address; bits [1:0] ignored.
- `data_in` input 32 — write data; only [7:0] used.
- `write_enable` input 1 — write strobe, already qualified by device select.
- `window_size` input 2 — access width; writes of any width accepted, no effect on behaviour.
- `data_out` input-side read data, output 32 — registered status word.
- `uart_tx` output 1 — serial line, idle high.
- `busy` output 1 — high while FIFO non-empty or a frame is in progress.

## Operation
- Register map: 0x0 TXDATA (write pushes `data_in[7:0]`; reads return 0); 0x4 STATUS (read: bit0 full, bit1 empty, bit2 tx_active, bit3 overflow, bits[7+FIFO_DEPTH_LOG2... no]: bits [11:8] FIFO count, zero-extended, other bits 0; write with `data_in[3]`=1 clears overflow); 0x8/0xC reserved, read 0, writes ignored.
- FIFO: circular buffer, read/write pointers wrap modulo depth; count 0..depth.
- Push when full: byte dropped, overflow set (sticky). Full is evaluated on the count before that edge, so a push while full is dropped even if a pop happens the same cycle.
- Push and pop in same cycle while not full and not empty: both occur, count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `uart_tx`=1. If FIFO non-empty: pop head into shift register, go START.
  - START: `uart_tx`=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: `uart_tx`=shift[0] for CLKS_PER_BIT cycles per bit; shift right; after bit 7 go STOP.
  - STOP: `uart_tx`=1 for CLKS_PER_BIT cycles; then, if FIFO non-empty, pop and go directly to START (no idle gap), else IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, reset to 0 on every state entry; width ceil(log2(CLKS_PER_BIT)).
- tx_active = state != IDLE.

## Timing
- Reset values: `uart_tx`=1, `data_out`=0, `busy`=0, FIFO empty (count 0, pointers 0), overflow 0, state IDLE, counters 0.
- Reset mid-frame: next edge line high, frame truncated, FIFO contents discarded.
- Read latency: `data_out` updates on the edge after the address is presented (matches the SoC's registered read mux); status reflects state before that edge.
- Write at edge k (IDLE, FIFO empty): count=1 after k; pop and `uart_tx` low after edge k+1; busy high after edge k.
- Frame length: exactly 10*CLKS_PER_BIT cycles; back-to-back frames have zero idle cycles between stop and next start.
- `busy` falls on the same edge the FSM returns to IDLE with FIFO empty.
- Pop frees a FIFO slot on the edge of the IDLE/STOP→START transition; full clears then.

## Test plan
- Reset/idle: hold `rst_n`=0 4 cycles, release → `uart_tx`=1, STATUS read = 0x0000_0002 (empty), `busy`=0.
- Single byte (CLKS_PER_BIT=4): write 0xA5 to 0x0 at edge k → `uart_tx` low from k+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles; `busy` low at k+41.
- Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles → three frames, 120 cycles total, no idle gap; decoded bytes 0x00, 0xFF, 0x55 in order.
- Overflow (FIFO_DEPTH_LOG2=3): write 10 bytes 0x01..0x0A consecutively → first popped immediately, 8 more held, 10th dropped; STATUS shows full=1, overflow=1, count 8; line emits 0x01..0x09; write 0x8 to 0x4 clears overflow.
- Pointer wrap: 20 bytes written with waits on `full`=0 → all 20 transmitted in order, pointers wrap twice, never overflow.
- Reset mid-frame: reset during DATA bit 3 with 2 bytes queued → `uart_tx`=1 next cycle, STATUS empty, no further frames.
